mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store controller between a 64-bit access port and a byte-wide memory.
// Requests move one byte per cycle; loads are reassembled and sign/zero extended.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_load_format,
    input  logic [1:0]        req_store_format,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

    state_t            state;
    logic              r_write;
    logic [2:0]        r_load_fmt;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [2:0]        r_last;
    logic [2:0]        cnt;
    logic [63:0]       asm_data;

    logic [2:0]        req_last;
    logic              req_fmt_bad;
    logic [64:0]       req_end;
    logic              req_err;
    logic [2:0]        next_cnt;
    logic [2:0]        prev_cnt;
    logic [63:0]       final_word;
    logic [63:0]       ext_data;

    // Index of the last byte (N-1) for the incoming request.
    always_comb begin
        req_last    = 3'd0;
        req_fmt_bad = 1'b0;
        if (req_write) begin
            case (req_store_format)
                2'b00:   req_last = 3'd0;
                2'b01:   req_last = 3'd1;
                2'b10:   req_last = 3'd3;
                default: req_last = 3'd7;
            endcase
        end else begin
            case (req_load_format)
                3'b000, 3'b100: req_last = 3'd0;
                3'b001, 3'b101: req_last = 3'd1;
                3'b010, 3'b110: req_last = 3'd3;
                3'b011:         req_last = 3'd7;
                default:        req_fmt_bad = 1'b1;
            endcase
        end
    end

    // 65-bit sum so that addresses near 2^64 cannot wrap into range.
    assign req_end  = {1'b0, req_addr} + 65'(req_last) + 65'd1;
    assign req_err  = req_fmt_bad || (req_end > 65'(MEM_BYTES));
    assign next_cnt = cnt + 3'd1;
    assign prev_cnt = cnt - 3'd1;

    always_comb begin
        final_word = asm_data;
        final_word[{r_last, 3'b000} +: 8] = mem_rdata;
        case (r_load_fmt)
            3'b000:  ext_data = {{56{final_word[7]}},  final_word[7:0]};
            3'b001:  ext_data = {{48{final_word[15]}}, final_word[15:0]};
            3'b010:  ext_data = {{32{final_word[31]}}, final_word[31:0]};
            3'b100:  ext_data = {56'd0, final_word[7:0]};
            3'b101:  ext_data = {48'd0, final_word[15:0]};
            3'b110:  ext_data = {32'd0, final_word[31:0]};
            default: ext_data = final_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            r_write    <= 1'b0;
            r_load_fmt <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 64'd0;
            r_last     <= 3'd0;
            cnt        <= 3'd0;
            asm_data   <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_write    <= req_write;
                        r_load_fmt <= req_load_format;
                        r_addr     <= req_addr[ADDR_W-1:0];
                        r_wdata    <= req_wdata;
                        r_last     <= req_last;
                        cnt        <= 3'd0;
                        req_ready  <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else begin
                            state     <= XFER;
                            mem_en    <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr[ADDR_W-1:0];
                            mem_wdata <= req_write ? req_wdata[7:0] : 8'd0;
                        end
                    end
                end
                XFER: begin
                    // Read data trails the strobe by one cycle, so cycle k returns byte k-1.
                    if (!r_write && cnt != 3'd0)
                        asm_data[{prev_cnt, 3'b000} +: 8] <= mem_rdata;
                    if (cnt == r_last) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= 8'd0;
                        if (r_write) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 64'd0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt       <= next_cnt;
                        mem_addr  <= r_addr + ADDR_W'(next_cnt);
                        mem_wdata <= r_write ? r_wdata[{next_cnt, 3'b000} +: 8] : 8'd0;
                    end
                end
                DRAIN: begin
                    asm_data[{r_last, 3'b000} +: 8] <= mem_rdata;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_data;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a synchronous byte-memory model.
// Expected values are hand-computed from the stored bytes and the load formats.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_load_format = 3'd0;
    logic [1:0]  req_store_format = 2'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  mem [0:2047];
    int          vec_count = 0;
    int          err_count = 0;

    mem_access_ctrl #(.MEM_BYTES(2048), .ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_load_format(req_load_format), .req_store_format(req_store_format),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in the cycle after acceptance.
    task automatic applyStimulus(input logic wr, input logic [2:0] lf, input logic [1:0] sf,
                                 input logic [63:0] addr, input logic [63:0] wd);
        req_write        = wr;
        req_load_format  = lf;
        req_store_format = sf;
        req_addr         = addr;
        req_wdata        = wd;
        req_valid        = 1'b1;
        tick();
        req_valid        = 1'b0;
    endtask

    task automatic waitResp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic doLoad(input string tag, input logic [2:0] lf, input logic [63:0] addr,
                          input int exp_lat, input logic [63:0] exp_data);
        int lat;
        applyStimulus(1'b0, lf, 2'd0, addr, 64'h0);
        waitResp(lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_data"}, resp_rdata, exp_data);
        checkOutput({tag, "_err"}, 64'(resp_err), 64'd0);
        tick();
    endtask

    task automatic doErr(input string tag, input logic [2:0] lf, input logic [63:0] addr);
        applyStimulus(1'b0, lf, 2'd0, addr, 64'h0);
        checkOutput({tag, "_valid"}, 64'(resp_valid), 64'd1);
        checkOutput({tag, "_err"}, 64'(resp_err), 64'd1);
        checkOutput({tag, "_data"}, resp_rdata, 64'd0);
        checkOutput({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        tick();
        checkOutput({tag, "_mem_en2"}, 64'(mem_en), 64'd0);
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [63:0] sd_data;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_err", 64'(resp_err), 64'd0);
        checkOutput("rst_rdata", resp_rdata, 64'd0);
        checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // sd at 0x10: eight write strobes then a response at T+9.
        sd_data = 64'h8877665544332211;
        checkOutput("sd_ready", 64'(req_ready), 64'd1);
        applyStimulus(1'b1, 3'd0, 2'b11, 64'h10, sd_data);
        for (int k = 0; k < 8; k++) begin
            checkOutput("sd_mem_en", 64'(mem_en), 64'd1);
            checkOutput("sd_mem_we", 64'(mem_we), 64'd1);
            checkOutput("sd_mem_addr", 64'(mem_addr), 64'h10 + 64'(k));
            checkOutput("sd_mem_wdata", 64'(mem_wdata), 64'(8'h11 * (k + 1)));
            checkOutput("sd_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        checkOutput("sd_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("sd_resp_err", 64'(resp_err), 64'd0);
        checkOutput("sd_resp_rdata", resp_rdata, 64'd0);
        checkOutput("sd_resp_mem_en", 64'(mem_en), 64'd0);
        tick();
        checkOutput("sd_resp_pulse", 64'(resp_valid), 64'd0);

        // lb 0x80 at 0x10, with per-cycle checks of the read strobe.
        mem[11'h10] = 8'h80;
        applyStimulus(1'b0, 3'b000, 2'd0, 64'h10, 64'h0);
        checkOutput("lb_mem_en", 64'(mem_en), 64'd1);
        checkOutput("lb_mem_we", 64'(mem_we), 64'd0);
        checkOutput("lb_mem_addr", 64'(mem_addr), 64'h10);
        tick();
        checkOutput("lb_drain_en", 64'(mem_en), 64'd0);
        checkOutput("lb_drain_valid", 64'(resp_valid), 64'd0);
        tick();
        checkOutput("lb_valid", 64'(resp_valid), 64'd1);
        checkOutput("lb_data", resp_rdata, 64'hFFFFFFFFFFFFFF80);
        tick();
        checkOutput("lb_hold", resp_rdata, 64'hFFFFFFFFFFFFFF80);

        doLoad("lbu", 3'b100, 64'h10, 3, 64'h0000000000000080);

        mem[11'h30] = 8'h34;
        mem[11'h31] = 8'hF2;
        doLoad("lh", 3'b001, 64'h30, 4, 64'hFFFFFFFFFFFFF234);
        doLoad("lhu", 3'b101, 64'h30, 4, 64'h000000000000F234);

        doErr("lw_cross", 3'b010, 64'h7FE);
        doErr("fmt111", 3'b111, 64'h10);
        doErr("lb_huge", 3'b000, 64'hFFFFFFFFFFFFFFFF);

        mem[11'h7FC] = 8'h01;
        mem[11'h7FD] = 8'h02;
        mem[11'h7FE] = 8'h03;
        mem[11'h7FF] = 8'h84;
        doLoad("lw_end", 3'b010, 64'h7FC, 6, 64'hFFFFFFFF84030201);

        doLoad("ld", 3'b011, 64'h10, 10, 64'h8877665544332280);

        // Unaligned sw then reloads of the same word.
        applyStimulus(1'b1, 3'd0, 2'b10, 64'h21, 64'h12345678DEADBEEF);
        waitResp(lat);
        checkOutput("sw_lat", 64'(lat), 64'd5);
        checkOutput("sw_rdata", resp_rdata, 64'd0);
        checkOutput("sw_err", 64'(resp_err), 64'd0);
        tick();
        doLoad("lwu", 3'b110, 64'h21, 6, 64'h00000000DEADBEEF);
        doLoad("lw", 3'b010, 64'h21, 6, 64'hFFFFFFFFDEADBEEF);

        // Reset during the third XFER cycle of an sd.
        applyStimulus(1'b1, 3'd0, 2'b11, 64'h50, 64'hAABBCCDDEEFF0102);
        tick();
        tick();
        checkOutput("abort_pre_en", 64'(mem_en), 64'd1);
        checkOutput("abort_pre_addr", 64'(mem_addr), 64'h52);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_en", 64'(mem_en), 64'd0);
        checkOutput("abort_mem_we", 64'(mem_we), 64'd0);
        checkOutput("abort_ready", 64'(req_ready), 64'd1);
        checkOutput("abort_rdata", resp_rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        checkOutput("abort_no_resp", 64'(seen), 64'd0);
        checkOutput("abort_byte0", 64'(mem[11'h50]), 64'h02);
        checkOutput("abort_byte1", 64'(mem[11'h51]), 64'h01);
        checkOutput("abort_byte2", 64'(mem[11'h52]), 64'h00);

        // Held request while busy; fields changed mid-access must be ignored.
        req_write = 1'b0; req_load_format = 3'b000; req_addr = 64'h10; req_valid = 1'b1;
        tick();
        req_load_format = 3'b100; req_addr = 64'h11;
        checkOutput("busy_ready1", 64'(req_ready), 64'd0);
        tick();
        checkOutput("busy_ready2", 64'(req_ready), 64'd0);
        tick();
        checkOutput("busy_resp1", 64'(resp_valid), 64'd1);
        checkOutput("busy_data1", resp_rdata, 64'hFFFFFFFFFFFFFF80);
        tick();
        checkOutput("busy_ready_idle", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("second_mem_en", 64'(mem_en), 64'd1);
        checkOutput("second_mem_addr", 64'(mem_addr), 64'h11);
        tick();
        tick();
        checkOutput("second_resp", 64'(resp_valid), 64'd1);
        checkOutput("second_data", resp_rdata, 64'h0000000000000022);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
